mips_multicycle_ctrl: RTL and testbench

//  Main control FSM for the multicycle MIPS datapath. Sequences fetch/decode/execute/memory/writeback

---
 rtl/mips_multicycle_ctrl_if.sv | 36 +++
 rtl/mips_multicycle_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_multicycle_ctrl_if.sv
// Control/status bundle between the multicycle MIPS controller and its datapath/memory.
// master = controller side, slave = datapath side.
interface mips_multicycle_ctrl_if;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       mem_ready;
    logic       mem_req;
    logic       MemWrite;
    logic       IRWrite;
    logic       PCEn;
    logic       RegWrite;
    logic       IorD;
    logic       MemtoReg;
    logic       RegDst;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSrc;
    logic       ExtOp;
    logic       illegal_op;
    logic       bus_err;
    logic [3:0] state;

    modport master (
        input  Op, Funct, Zero, mem_ready,
        output mem_req, MemWrite, IRWrite, PCEn, RegWrite, IorD, MemtoReg, RegDst,
               ALUSrcA, ALUSrcB, ALUOp, PCSrc, ExtOp, illegal_op, bus_err, state
    );

    modport slave (
        output Op, Funct, Zero, mem_ready,
        input  mem_req, MemWrite, IRWrite, PCEn, RegWrite, IorD, MemtoReg, RegDst,
               ALUSrcA, ALUSrcB, ALUOp, PCSrc, ExtOp, illegal_op, bus_err, state
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath, with a memory ready handshake
// and a per-access timeout that aborts to FETCH with a bus_err pulse.
module mips_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8     // 2**CNT_W must exceed MEM_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst,
    mips_multicycle_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REX    = 4'd6,
        S_ALUWB  = 4'd7,
        S_BREX   = 4'd8,
        S_IMMEX  = 4'd9,
        S_IMMWB  = 4'd10,
        S_JEX    = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state_reg, state_next, cur_state;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             mem_wait, timeout;
    logic             pc_write, branch, branch_ne;
    logic             unused_funct;

    // Funct is decoded downstream from ALUOp; the FSM never looks at it.
    assign unused_funct = ^bus.Funct;

    // Waiting cycle in a memory state; the last allowed waiting cycle aborts the access.
    assign mem_wait = ((state_reg == S_FETCH) || (state_reg == S_MEMRD) || (state_reg == S_MEMWR))
                      && !bus.mem_ready;
    assign timeout  = mem_wait && (cnt_reg == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_FETCH;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_FETCH:  if (bus.mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (bus.Op)
                    OP_LW, OP_SW:              state_next = S_MEMADR;
                    OP_R:                      state_next = S_REX;
                    OP_BEQ, OP_BNE:            state_next = S_BREX;
                    OP_ADDI, OP_ANDI, OP_ORI:  state_next = S_IMMEX;
                    OP_J:                      state_next = S_JEX;
                    default:                   state_next = S_FETCH;
                endcase
            end
            S_MEMADR: state_next = (bus.Op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  begin
                if (bus.mem_ready)  state_next = S_MEMWB;
                else if (timeout)   state_next = S_FETCH;
            end
            S_MEMWR:  if (bus.mem_ready || timeout) state_next = S_FETCH;
            S_REX:    state_next = S_ALUWB;
            S_BREX:   state_next = S_FETCH;
            S_IMMEX:  state_next = S_IMMWB;
            S_JEX:    state_next = S_FETCH;
            default:  state_next = S_FETCH;
        endcase
        // A timed-out fetch stays in FETCH but must still restart its count.
        if ((state_next != state_reg) || timeout)
            cnt_next = '0;
        else if (mem_wait)
            cnt_next = cnt_reg + CNT_W'(1);
    end

    always_comb begin
        cur_state      = rst ? S_FETCH : state_reg;
        pc_write       = 1'b0;
        branch         = 1'b0;
        branch_ne      = 1'b0;
        bus.mem_req    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.IorD       = 1'b0;
        bus.MemtoReg   = 1'b0;
        bus.RegDst     = 1'b0;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = 2'b00;
        bus.ALUOp      = 2'b00;
        bus.PCSrc      = 2'b00;
        bus.ExtOp      = 1'b0;
        bus.illegal_op = 1'b0;
        bus.bus_err    = 1'b0;
        case (cur_state)
            S_FETCH: begin
                bus.mem_req = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.IRWrite = bus.mem_ready;
                pc_write    = bus.mem_ready;
                bus.bus_err = timeout;
            end
            S_DECODE: begin
                bus.ALUSrcB    = 2'b11;
                bus.ExtOp      = 1'b1;
                bus.illegal_op = (state_next == S_FETCH);
            end
            S_MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                bus.ExtOp   = 1'b1;
            end
            S_MEMRD: begin
                bus.mem_req = 1'b1;
                bus.IorD    = 1'b1;
                bus.bus_err = timeout;
            end
            S_MEMWB: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                bus.mem_req  = 1'b1;
                bus.IorD     = 1'b1;
                bus.MemWrite = bus.mem_ready;
                bus.bus_err  = timeout;
            end
            S_REX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = 2'b10;
            end
            S_ALUWB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = 1'b1;
            end
            S_BREX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = 2'b01;
                bus.PCSrc   = 2'b01;
                branch      = 1'b1;
                branch_ne   = bus.Op[0];
            end
            S_IMMEX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                bus.ExtOp   = (bus.Op == OP_ADDI);
                bus.ALUOp   = (bus.Op == OP_ADDI) ? 2'b00 : 2'b11;
            end
            S_IMMWB: begin
                bus.RegWrite = 1'b1;
                bus.ExtOp    = (bus.Op == OP_ADDI);
            end
            S_JEX: begin
                bus.PCSrc = 2'b10;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
        // Reset overrides every strobe; cur_state already shows FETCH values.
        if (rst) begin
            bus.mem_req    = 1'b0;
            bus.MemWrite   = 1'b0;
            bus.IRWrite    = 1'b0;
            bus.RegWrite   = 1'b0;
            bus.illegal_op = 1'b0;
            bus.bus_err    = 1'b0;
            pc_write       = 1'b0;
        end
        bus.PCEn  = pc_write | (branch & (bus.Zero ^ branch_ne));
        bus.state = cur_state;
    end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Table-driven, scoreboarded bench for mips_multicycle_ctrl: instruction flows,
// branch polarity, ExtOp selection, illegal opcode, reset abort and memory timeout.
module tb_mips_multicycle_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mips_multicycle_ctrl_if bus();

    mips_multicycle_ctrl #(.MEM_TIMEOUT(255), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req, MemWrite, IRWrite, PCEn, RegWrite, IorD, MemtoReg, RegDst, ALUSrcA;
        logic [1:0] ALUSrcB, ALUOp, PCSrc;
        logic       ExtOp, illegal_op, bus_err;
    } out_t;

    typedef struct {
        string      name;
        logic       rst;
        logic [5:0] op;
        logic       zero;
        logic       ready;
        logic [3:0] st;
        logic       pcen, irw, memw, ill, berr;
    } vec_t;

    typedef struct {
        string name;
        out_t  exp;
    } sb_t;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101;
    localparam logic [5:0] JMP = 6'b000010, BAD = 6'b111111;

    vec_t tbl[$];
    sb_t  sbq[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Expected Moore outputs of each state, straight from the state descriptions.
    function automatic out_t expect_of(vec_t v);
        out_t e = '0;
        e.st = v.st;
        case (v.st)
            4'd0:  begin e.mem_req = 1; e.ALUSrcB = 2'b01; end
            4'd1:  begin e.ALUSrcB = 2'b11; e.ExtOp = 1; end
            4'd2:  begin e.ALUSrcA = 1; e.ALUSrcB = 2'b10; e.ExtOp = 1; end
            4'd3:  begin e.mem_req = 1; e.IorD = 1; end
            4'd4:  begin e.RegWrite = 1; e.MemtoReg = 1; end
            4'd5:  begin e.mem_req = 1; e.IorD = 1; end
            4'd6:  begin e.ALUSrcA = 1; e.ALUOp = 2'b10; end
            4'd7:  begin e.RegWrite = 1; e.RegDst = 1; end
            4'd8:  begin e.ALUSrcA = 1; e.ALUOp = 2'b01; e.PCSrc = 2'b01; end
            4'd9:  begin e.ALUSrcA = 1; e.ALUSrcB = 2'b10;
                         e.ExtOp = (v.op == ADDI); e.ALUOp = (v.op == ADDI) ? 2'b00 : 2'b11; end
            4'd10: begin e.RegWrite = 1; e.ExtOp = (v.op == ADDI); end
            4'd11: begin e.PCSrc = 2'b10; end
            default: ;
        endcase
        e.PCEn = v.pcen; e.IRWrite = v.irw; e.MemWrite = v.memw;
        e.illegal_op = v.ill; e.bus_err = v.berr;
        if (v.rst) begin e.mem_req = 0; e.RegWrite = 0; end
        return e;
    endfunction

    function automatic vec_t mk(string n, logic r, logic [5:0] op, logic z, logic rdy,
                                logic [3:0] st, logic pcen, logic irw, logic memw,
                                logic ill, logic berr);
        vec_t v;
        v.name = n; v.rst = r; v.op = op; v.zero = z; v.ready = rdy; v.st = st;
        v.pcen = pcen; v.irw = irw; v.memw = memw; v.ill = ill; v.berr = berr;
        return v;
    endfunction

    task automatic apply(vec_t v);
        sb_t s;
        @(posedge clk);
        #1;
        rst           = v.rst;
        bus.Op        = v.op;
        bus.Funct     = 6'h20;
        bus.Zero      = v.zero;
        bus.mem_ready = v.ready;
        s.name = v.name;
        s.exp  = expect_of(v);
        sbq.push_back(s);
    endtask

    // Fetch of an instruction with immediate mem_ready: FETCH then DECODE.
    task automatic push_fetch(string n, logic [5:0] op, logic z);
        tbl.push_back(mk({n, "_fetch"},  0, op, z, 1, 4'd0, 1, 1, 0, 0, 0));
        tbl.push_back(mk({n, "_decode"}, 0, op, z, 1, 4'd1, 0, 0, 0, 0, 0));
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            sb_t  s;
            out_t act;
            s = sbq.pop_front();
            act = '{st: bus.state, mem_req: bus.mem_req, MemWrite: bus.MemWrite,
                    IRWrite: bus.IRWrite, PCEn: bus.PCEn, RegWrite: bus.RegWrite,
                    IorD: bus.IorD, MemtoReg: bus.MemtoReg, RegDst: bus.RegDst,
                    ALUSrcA: bus.ALUSrcA, ALUSrcB: bus.ALUSrcB, ALUOp: bus.ALUOp,
                    PCSrc: bus.PCSrc, ExtOp: bus.ExtOp, illegal_op: bus.illegal_op,
                    bus_err: bus.bus_err};
            n_vec++;
            if (act !== s.exp) begin
                n_err++;
                $display("FAIL %s: got %h required %h", s.name, act, s.exp);
            end else begin
                $display("vec %0d %s state=%0d ok", n_vec, s.name, act.st);
            end
        end
    end

    initial begin
        bus.Op = 6'd0; bus.Funct = 6'd0; bus.Zero = 1'b0; bus.mem_ready = 1'b0;

        // Reset held two cycles: FETCH values with all strobes low.
        tbl.push_back(mk("reset0", 1, LW, 0, 1, 4'd0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("reset1", 1, LW, 0, 1, 4'd0, 0, 0, 0, 0, 0));
        push_fetch("lw", LW, 0);
        tbl.push_back(mk("lw_memadr", 0, LW, 0, 1, 4'd2, 0, 0, 0, 0, 0));
        tbl.push_back(mk("lw_memrd",  0, LW, 0, 1, 4'd3, 0, 0, 0, 0, 0));
        tbl.push_back(mk("lw_memwb",  0, LW, 0, 1, 4'd4, 0, 0, 0, 0, 0));
        push_fetch("sw", SW, 0);
        tbl.push_back(mk("sw_memadr", 0, SW, 0, 1, 4'd2, 0, 0, 0, 0, 0));
        tbl.push_back(mk("sw_memwr",  0, SW, 0, 1, 4'd5, 0, 0, 1, 0, 0));
        push_fetch("rtype", RT, 0);
        tbl.push_back(mk("rtype_rex",   0, RT, 0, 1, 4'd6, 0, 0, 0, 0, 0));
        tbl.push_back(mk("rtype_aluwb", 0, RT, 0, 1, 4'd7, 0, 0, 0, 0, 0));
        push_fetch("beq_z1", BEQ, 1);
        tbl.push_back(mk("beq_z1_brex", 0, BEQ, 1, 1, 4'd8, 1, 0, 0, 0, 0));
        push_fetch("beq_z0", BEQ, 0);
        tbl.push_back(mk("beq_z0_brex", 0, BEQ, 0, 1, 4'd8, 0, 0, 0, 0, 0));
        push_fetch("bne_z1", BNE, 1);
        tbl.push_back(mk("bne_z1_brex", 0, BNE, 1, 1, 4'd8, 0, 0, 0, 0, 0));
        push_fetch("bne_z0", BNE, 0);
        tbl.push_back(mk("bne_z0_brex", 0, BNE, 0, 1, 4'd8, 1, 0, 0, 0, 0));
        push_fetch("andi", ANDI, 0);
        tbl.push_back(mk("andi_immex", 0, ANDI, 0, 1, 4'd9,  0, 0, 0, 0, 0));
        tbl.push_back(mk("andi_immwb", 0, ANDI, 0, 1, 4'd10, 0, 0, 0, 0, 0));
        push_fetch("addi", ADDI, 0);
        tbl.push_back(mk("addi_immex", 0, ADDI, 0, 1, 4'd9,  0, 0, 0, 0, 0));
        tbl.push_back(mk("addi_immwb", 0, ADDI, 0, 1, 4'd10, 0, 0, 0, 0, 0));
        push_fetch("ori", ORI, 0);
        tbl.push_back(mk("ori_immex", 0, ORI, 0, 1, 4'd9,  0, 0, 0, 0, 0));
        tbl.push_back(mk("ori_immwb", 0, ORI, 0, 1, 4'd10, 0, 0, 0, 0, 0));
        push_fetch("j", JMP, 0);
        tbl.push_back(mk("j_jex", 0, JMP, 0, 1, 4'd11, 1, 0, 0, 0, 0));
        tbl.push_back(mk("bad_fetch",  0, BAD, 0, 1, 4'd0, 1, 1, 0, 0, 0));
        tbl.push_back(mk("bad_decode", 0, BAD, 0, 1, 4'd1, 0, 0, 0, 1, 0));
        // Fetch stalls two cycles before mem_ready.
        tbl.push_back(mk("fwait0", 0, RT, 0, 0, 4'd0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("fwait1", 0, RT, 0, 0, 4'd0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("fwait_go", 0, RT, 0, 1, 4'd0, 1, 1, 0, 0, 0));
        tbl.push_back(mk("fwait_decode", 0, RT, 0, 1, 4'd1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("fwait_rex",    0, RT, 0, 1, 4'd6, 0, 0, 0, 0, 0));
        tbl.push_back(mk("fwait_aluwb",  0, RT, 0, 1, 4'd7, 0, 0, 0, 0, 0));
        // Store with write stall, then reset mid-MEMWR with mem_ready high.
        push_fetch("swr", SW, 0);
        tbl.push_back(mk("swr_memadr", 0, SW, 0, 1, 4'd2, 0, 0, 0, 0, 0));
        tbl.push_back(mk("swr_wait",   0, SW, 0, 0, 4'd5, 0, 0, 0, 0, 0));
        tbl.push_back(mk("swr_rst0",   1, SW, 0, 1, 4'd0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("swr_rst1",   1, SW, 0, 1, 4'd0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("swr_after",  0, SW, 0, 0, 4'd0, 0, 0, 0, 0, 0));

        foreach (tbl[i]) apply(tbl[i]);

        // Load whose read never completes: 254 quiet waits, bus_err on the 255th, back to FETCH.
        apply(mk("to_fetch",  0, LW, 0, 1, 4'd0, 1, 1, 0, 0, 0));
        apply(mk("to_decode", 0, LW, 0, 1, 4'd1, 0, 0, 0, 0, 0));
        apply(mk("to_memadr", 0, LW, 0, 1, 4'd2, 0, 0, 0, 0, 0));
        for (int k = 1; k < 255; k++) apply(mk("to_wait", 0, LW, 0, 0, 4'd3, 0, 0, 0, 0, 0));
        apply(mk("to_buserr", 0, LW, 0, 0, 4'd3, 0, 0, 0, 0, 1));
        apply(mk("to_retry",  0, LW, 0, 0, 4'd0, 0, 0, 0, 0, 0));

        // Same load, but mem_ready arrives in the 255th waiting cycle: completes, no bus_err.
        apply(mk("ok_fetch",  0, LW, 0, 1, 4'd0, 1, 1, 0, 0, 0));
        apply(mk("ok_decode", 0, LW, 0, 1, 4'd1, 0, 0, 0, 0, 0));
        apply(mk("ok_memadr", 0, LW, 0, 1, 4'd2, 0, 0, 0, 0, 0));
        for (int k = 1; k < 255; k++) apply(mk("ok_wait", 0, LW, 0, 0, 4'd3, 0, 0, 0, 0, 0));
        apply(mk("ok_ready", 0, LW, 0, 1, 4'd3, 0, 0, 0, 0, 0));
        apply(mk("ok_memwb", 0, LW, 0, 1, 4'd4, 0, 0, 0, 0, 0));
        apply(mk("ok_fetch2", 0, LW, 0, 0, 4'd0, 0, 0, 0, 0, 0));

        @(posedge clk);
        @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
